// File: rtl/axil_array_arb.sv
// Shares one single-port array between a read port and a write port, one transaction at a time.
// Define AXIL_ARB_WRITE_PRIORITY_EN for fixed write priority; otherwise reads and writes alternate under contention.
module axil_array_arb #(
  parameter int AW = 10,
  parameter int DW = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [AW-1:0] ra,
  input  logic          ra_valid,
  output logic          ra_ready,
  input  logic [AW-1:0] wa,
  input  logic          wa_valid,
  output logic          wa_ready,
  input  logic [DW-1:0] wd,
  input  logic          wd_valid,
  output logic          wd_ready,
  output logic [DW-1:0] rd,
  output logic          rd_valid,
  input  logic          rd_ready,
  output logic          b_valid,
  input  logic          b_ready,
  output logic [AW-1:0] mem_addr,
  output logic          mem_we,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata
);

  typedef enum logic [2:0] {IDLE, RD_ADDR, RD_CAP, RD_RESP, WR_RESP} state_t;

  state_t        state_reg, state_next;
  logic [AW-1:0] mem_addr_reg, mem_addr_next;
  logic          mem_we_reg, mem_we_next;
  logic [DW-1:0] mem_wdata_reg, mem_wdata_next;
  logic [DW-1:0] rd_reg, rd_next;
  logic          rd_valid_reg, rd_valid_next;
  logic          b_valid_reg, b_valid_next;

  logic rd_pend, wr_pend, grant_rd, grant_wr;

  // A write needs both address and data before it can compete for the array.
  assign rd_pend = ra_valid;
  assign wr_pend = wa_valid & wd_valid;

`ifdef AXIL_ARB_WRITE_PRIORITY_EN
  assign grant_rd = rd_pend & ~wr_pend;
`else
  logic ptr_rd_reg, ptr_rd_next;

  assign grant_rd = rd_pend & (~wr_pend | ptr_rd_reg);

  // Under contention the side that just lost gets preference next time.
  always_comb begin
    ptr_rd_next = ptr_rd_reg;
    if (state_reg == IDLE && rd_pend && wr_pend)
      ptr_rd_next = ~grant_rd;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) ptr_rd_reg <= 1'b1;
    else     ptr_rd_reg <= ptr_rd_next;
  end
`endif

  assign grant_wr = wr_pend & ~grant_rd;

  assign ra_ready  = (state_reg == IDLE) & grant_rd;
  assign wa_ready  = (state_reg == IDLE) & grant_wr;
  assign wd_ready  = wa_ready;
  assign rd        = rd_reg;
  assign rd_valid  = rd_valid_reg;
  assign b_valid   = b_valid_reg;
  assign mem_addr  = mem_addr_reg;
  assign mem_we    = mem_we_reg;
  assign mem_wdata = mem_wdata_reg;

  always_comb begin
    state_next     = state_reg;
    mem_addr_next  = mem_addr_reg;
    mem_we_next    = mem_we_reg;
    mem_wdata_next = mem_wdata_reg;
    rd_next        = rd_reg;
    rd_valid_next  = rd_valid_reg;
    b_valid_next   = b_valid_reg;
    case (state_reg)
      IDLE: begin
        if (grant_rd) begin
          mem_addr_next = ra;
          mem_we_next   = 1'b0;
          state_next    = RD_ADDR;
        end else if (grant_wr) begin
          mem_addr_next  = wa;
          mem_wdata_next = wd;
          mem_we_next    = 1'b1;
          state_next     = WR_RESP;
        end
      end
      RD_ADDR: state_next = RD_CAP;
      // Array output is valid the cycle after it samples mem_addr.
      RD_CAP: begin
        rd_next       = mem_rdata;
        rd_valid_next = 1'b1;
        state_next    = RD_RESP;
      end
      RD_RESP: begin
        if (rd_ready) begin
          rd_valid_next = 1'b0;
          state_next    = IDLE;
        end
      end
      WR_RESP: begin
        if (!b_valid_reg) begin
          mem_we_next  = 1'b0;
          b_valid_next = 1'b1;
        end else if (b_ready) begin
          b_valid_next = 1'b0;
          state_next   = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg     <= IDLE;
      mem_addr_reg  <= '0;
      mem_we_reg    <= 1'b0;
      mem_wdata_reg <= '0;
      rd_reg        <= '0;
      rd_valid_reg  <= 1'b0;
      b_valid_reg   <= 1'b0;
    end else begin
      state_reg     <= state_next;
      mem_addr_reg  <= mem_addr_next;
      mem_we_reg    <= mem_we_next;
      mem_wdata_reg <= mem_wdata_next;
      rd_reg        <= rd_next;
      rd_valid_reg  <= rd_valid_next;
      b_valid_reg   <= b_valid_next;
    end
  end

endmodule

// File: tb/tb_axil_array_arb.sv
// Scoreboard bench for axil_array_arb: stimulus queues expected grants/responses, a negedge monitor checks them.
// Build with AXIL_ARB_WRITE_PRIORITY_EN defined to check the fixed write-priority variant.
module tb_axil_array_arb;
  localparam int AW = 10;
  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [AW-1:0] ra = '0, wa = '0;
  logic          ra_valid = 1'b0, wa_valid = 1'b0, wd_valid = 1'b0;
  logic [DW-1:0] wd = '0;
  logic          rd_ready = 1'b1, b_ready = 1'b1;
  logic          ra_ready, wa_ready, wd_ready, rd_valid, b_valid, mem_we;
  logic [DW-1:0] rd, mem_wdata, mem_rdata;
  logic [AW-1:0] mem_addr;

  int tests = 0;
  int fails = 0;
  int cyc = 0;

  byte           grant_q[$];
  logic [DW-1:0] rd_q[$];
  logic [AW+DW-1:0] mem_q[$];
  int            b_q[$];

  axil_array_arb #(.AW(AW), .DW(DW)) dut (
    .clk(clk), .rst(rst),
    .ra(ra), .ra_valid(ra_valid), .ra_ready(ra_ready),
    .wa(wa), .wa_valid(wa_valid), .wa_ready(wa_ready),
    .wd(wd), .wd_valid(wd_valid), .wd_ready(wd_ready),
    .rd(rd), .rd_valid(rd_valid), .rd_ready(rd_ready),
    .b_valid(b_valid), .b_ready(b_ready),
    .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  // Single-port array with registered read.
  logic [DW-1:0] mem [0:(1<<AW)-1];
  always @(posedge clk) begin
    if (mem_we) mem[mem_addr] <= mem_wdata;
    mem_rdata <= mem[mem_addr];
  end

  function automatic void check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endfunction

  function automatic byte pop_grant();
    if (grant_q.size() == 0) return "?";
    return grant_q.pop_front();
  endfunction

  function automatic void exp_rd(input logic [DW-1:0] d);
    rd_q.push_back(d);
  endfunction

  function automatic void exp_wr(input logic [AW-1:0] a, input logic [DW-1:0] d);
    mem_q.push_back({a, d});
    b_q.push_back(1);
  endfunction

  // Monitor: sampled on the falling edge, reflects what the next rising edge will do.
  initial begin
    logic rd_valid_prev, rd_ready_prev, b_valid_prev, mem_we_prev;
    int racc, wacc;
    byte g;
    rd_valid_prev = 0; rd_ready_prev = 1; b_valid_prev = 0; mem_we_prev = 0;
    racc = 0; wacc = 0;
    forever begin
      @(negedge clk);
      cyc++;
      if (rst) begin
        rd_valid_prev = 0; rd_ready_prev = 1; b_valid_prev = 0; mem_we_prev = 0;
      end else begin
        check("wd_ready_eq_wa_ready", wd_ready, wa_ready);
        if (rd_valid || b_valid) check("ready_while_busy", {ra_ready, wa_ready}, 0);
        if (ra_valid && ra_ready) begin
          racc = cyc;
          g = pop_grant();
          check("grant_order_R", 64'("R"), 64'(g));
          $display("[TB] cycle %0d read accept addr %0d", cyc, ra);
        end
        if (wa_valid && wa_ready) begin
          wacc = cyc;
          g = pop_grant();
          check("grant_order_W", 64'("W"), 64'(g));
          $display("[TB] cycle %0d write accept addr %0d data 0x%0h", cyc, wa, wd);
        end
        if (mem_we) begin
          check("mem_we_width", mem_we_prev, 0);
          check("mem_we_latency", cyc - wacc, 1);
          if (mem_q.size() == 0) check("mem_we_unexpected", 1, 0);
          else check("mem_cmd", {mem_addr, mem_wdata}, mem_q.pop_front());
        end
        if (rd_valid && !rd_valid_prev) check("rd_latency", cyc - racc, 3);
        if (rd_valid_prev && !rd_ready_prev) check("rd_valid_hold", rd_valid, 1);
        if (rd_valid && rd_q.size() != 0) check("rd_data_stable", rd, rd_q[0]);
        if (rd_valid && rd_ready) begin
          if (rd_q.size() == 0) check("rd_unexpected", 1, 0);
          else begin
            $display("[TB] cycle %0d read response data 0x%0h", cyc, rd);
            void'(rd_q.pop_front());
          end
        end
        if (b_valid && !b_valid_prev) check("b_latency", cyc - wacc, 2);
        if (b_valid && b_ready) begin
          if (b_q.size() == 0) check("b_unexpected", 1, 0);
          else begin
            $display("[TB] cycle %0d write response", cyc);
            void'(b_q.pop_front());
          end
        end
        rd_valid_prev = rd_valid; rd_ready_prev = rd_ready;
        b_valid_prev = b_valid; mem_we_prev = mem_we;
      end
    end
  end

  // Drivers: called #1 after a rising edge; hold valid until accepted.
  task automatic do_read(input logic [AW-1:0] a);
    int n;
    n = 0;
    ra = a; ra_valid = 1'b1;
    do begin @(negedge clk); n++; end while (!ra_ready && n < 200);
    check("read_accept_timeout", ra_ready, 1);
    @(posedge clk); #1;
    ra_valid = 1'b0;
  endtask

  task automatic do_write(input logic [AW-1:0] a, input logic [DW-1:0] d);
    int n;
    n = 0;
    wa = a; wd = d; wa_valid = 1'b1; wd_valid = 1'b1;
    do begin @(negedge clk); n++; end while (!wa_ready && n < 200);
    check("write_accept_timeout", wa_ready, 1);
    @(posedge clk); #1;
    wa_valid = 1'b0; wd_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((grant_q.size() + rd_q.size() + mem_q.size() + b_q.size()) != 0 && n < 300) begin
      @(negedge clk); n++;
    end
    check("drain_timeout", n < 300, 1);
    @(posedge clk); #1;
  endtask

  task automatic seq_write(input logic [AW-1:0] a, input logic [DW-1:0] d);
    grant_q.push_back("W"); exp_wr(a, d);
    do_write(a, d);
    drain();
  endtask

  task automatic seq_read(input logic [AW-1:0] a, input logic [DW-1:0] d);
    grant_q.push_back("R"); exp_rd(d);
    do_read(a);
    drain();
  endtask

  initial begin
    int n;
    repeat (3) @(posedge clk);
    #1;
    check("reset_rd_valid", rd_valid, 0);
    check("reset_b_valid", b_valid, 0);
    check("reset_mem_we", mem_we, 0);
    check("reset_mem_addr", mem_addr, 0);
    check("reset_mem_wdata", mem_wdata, 0);
    check("reset_rd", rd, 0);
    rst = 1'b0;

    // Lone write then read-back of the same address.
    seq_write(5, 32'h0000_1234);
    seq_read(5, 32'h0000_1234);

    seq_write(10, 32'h0000_A0A0);
    seq_write(11, 32'h0000_B1B1);
    seq_write(1023, 32'hDEAD_BEEF);
    seq_write(12, 32'h0000_C2C2);

    // Reads and writes contending continuously.
`ifdef AXIL_ARB_WRITE_PRIORITY_EN
    grant_q.push_back("W"); grant_q.push_back("W"); grant_q.push_back("W");
    grant_q.push_back("R"); grant_q.push_back("R"); grant_q.push_back("R");
`else
    grant_q.push_back("R"); grant_q.push_back("W"); grant_q.push_back("R");
    grant_q.push_back("W"); grant_q.push_back("R"); grant_q.push_back("W");
`endif
    exp_rd(32'h0000_A0A0); exp_rd(32'h0000_B1B1); exp_rd(32'h0000_C2C2);
    exp_wr(20, 32'h0000_2020); exp_wr(21, 32'h0000_2121); exp_wr(22, 32'h0000_2222);
    fork
      begin do_read(10); do_read(11); do_read(12); end
      begin do_write(20, 32'h2020); do_write(21, 32'h2121); do_write(22, 32'h2222); end
    join
    drain();

    // Read-data backpressure with a second read waiting.
    rd_ready = 1'b0;
    grant_q.push_back("R"); exp_rd(32'h0000_A0A0);
    do_read(10);
    grant_q.push_back("R"); exp_rd(32'h0000_B1B1);
    ra = 11; ra_valid = 1'b1;
    n = 0;
    do begin @(negedge clk); n++; end while (!rd_valid && n < 50);
    check("rd_valid_timeout", rd_valid, 1);
    repeat (5) @(negedge clk);
    @(posedge clk); #1;
    rd_ready = 1'b1;
    @(negedge clk);
    check("ra_ready_at_handshake", ra_ready, 0);
    @(negedge clk);
    check("ra_ready_after_handshake", ra_ready, 1);
    @(posedge clk); #1;
    ra_valid = 1'b0;
    drain();

    // Write address without data is not a request.
    wa = 30; wd = 32'h3030; wa_valid = 1'b1; wd_valid = 1'b0;
    grant_q.push_back("R"); grant_q.push_back("R");
    exp_rd(32'h0000_A0A0); exp_rd(32'h0000_B1B1);
    do_read(10); do_read(11);
    drain();
    @(negedge clk);
    check("wa_ready_without_wd", wa_ready, 0);
    @(posedge clk); #1;
    wa_valid = 1'b0;

    // Reset during RD_CAP abandons the read.
    grant_q.push_back("R");
    do_read(12);
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    check("midreset_rd_valid", rd_valid, 0);
    check("midreset_mem_we", mem_we, 0);
    check("midreset_mem_addr", mem_addr, 0);
    @(posedge clk); #1;
    check("midreset_rd_valid_held", rd_valid, 0);
    rst = 1'b0;

    // First edge after reset accepts; pointer is back to read-preferred.
`ifdef AXIL_ARB_WRITE_PRIORITY_EN
    grant_q.push_back("W"); grant_q.push_back("R");
`else
    grant_q.push_back("R"); grant_q.push_back("W");
`endif
    exp_rd(32'hDEAD_BEEF);
    exp_wr(40, 32'h0000_4040);
    fork
      do_read(1023);
      do_write(40, 32'h4040);
      begin @(negedge clk); check("first_accept_after_reset", ra_ready | wa_ready, 1); end
    join
    drain();

    seq_read(20, 32'h0000_2020);
    seq_read(22, 32'h0000_2222);
    seq_read(40, 32'h0000_4040);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish (tests %0d, failed %0d)", tests, fails);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/axil_array_arb.md
AXIL_ARRAY_ARB -- requirements
Module: axil_array_arb

Interface
REQ-001 Parameter AW, default 10, address width of array port and address streams.
REQ-002 Parameter DW, default 32, data width of array and data streams.
REQ-003 clk  in  1  single clock, all state on rising edge.
REQ-004 rst  in  1  reset, asynchronous, active-high.
REQ-005 ra, ra_valid, ra_ready  in/in/out  AW/1/1  read-address stream.
REQ-006 wa, wa_valid, wa_ready  in/in/out  AW/1/1  write-address stream.
REQ-007 wd, wd_valid, wd_ready  in/in/out  DW/1/1  write-data stream.
REQ-008 rd, rd_valid, rd_ready  out/out/in  DW/1/1  read-data stream.
REQ-009 b_valid, b_ready  out/in  1/1  write-response null stream, no data.
REQ-010 mem_addr, mem_we, mem_wdata  out/out/out  AW/1/DW  registered single-port array command.
REQ-011 mem_rdata  in  DW  array read data, valid one cycle after mem_addr is sampled.

Function
REQ-012 The block SHALL share one single-port array between one reader and one writer, at most one transaction outstanding.
REQ-013 FSM states SHALL be IDLE, RD_ADDR, RD_CAP, RD_RESP, WR_RESP.
REQ-014 Read pending = ra_valid; write pending = wa_valid & wd_valid; a write with only one of wa/wd valid SHALL NOT be pending.
REQ-015 Ready outputs SHALL be high only in IDLE: ra_ready = IDLE & read granted; wa_ready = wd_ready = IDLE & write granted.
REQ-016 Grant: single pending requester wins; both pending -> requester selected by priority pointer.
REQ-017 Pointer SHALL flip to the non-granted side after every accepted transaction while both were pending; otherwise unchanged.
REQ-018 Read accept at edge k: mem_addr <= ra, mem_we <= 0, state RD_ADDR; edge k+1: RD_CAP; edge k+2: rd <= mem_rdata, rd_valid <= 1, state RD_RESP.
REQ-019 Write accept at edge k: mem_addr <= wa, mem_wdata <= wd, mem_we <= 1, state WR_RESP; edge k+1: mem_we <= 0, b_valid <= 1.
REQ-020 mem_we SHALL be high for exactly one cycle per write, never during reads.
REQ-021 rd/rd_valid SHALL hold stable in RD_RESP until rd_ready; on rd_valid & rd_ready: rd_valid <= 0, state IDLE.
REQ-022 b_valid SHALL hold until b_ready; on b_valid & b_ready: b_valid <= 0, state IDLE.
REQ-023 Minimum spacing: read 4 cycles accept-to-accept, write 3 cycles, with ready consumers.
REQ-024 Address wraps at 2^AW by truncation; no range check.
REQ-025 Read to address just written SHALL return new data (write retires before next accept).
REQ-026 Input valid deassertion while not ready SHALL have no effect; no request SHALL be dropped once accepted.

Reset
REQ-027 rst high SHALL force, asynchronously: state IDLE, rd_valid 0, b_valid 0, mem_we 0, mem_addr 0, mem_wdata 0, rd 0, pointer = read-preferred.
REQ-028 Reset mid-transaction SHALL abandon it with no response; in-flight write is either committed or not, but mem_we SHALL be 0 during and after reset.
REQ-029 First accept SHALL be possible on the first edge after rst falls.

Configuration
REQ-030 Macro AXIL_ARB_WRITE_PRIORITY_EN defined: write always wins when both pending, pointer unused.
REQ-031 Macro undefined: round-robin per REQ-017.

Verification
REQ-032 Write wa=5, wd=0x1234 alone, b_ready=1 -> mem_we one cycle with addr 5 data 0x1234, b_valid one cycle later, then read ra=5 -> rd=0x1234, 3 cycles after accept.
REQ-033 Read and write both pending continuously (no macro) -> grants alternate R,W,R,W starting with read after reset.
REQ-034 Same stimulus with AXIL_ARB_WRITE_PRIORITY_EN -> all writes served before any read.
REQ-035 rd_ready held low 5 cycles -> rd stable, ra_ready low throughout, accept resumes the cycle after handshake.
REQ-036 wa_valid=1, wd_valid=0 for 4 cycles with read pending -> reads served, no write accepted, mem_we never high.
REQ-037 rst pulsed in RD_CAP -> rd_valid never asserts, state IDLE, next read ra=N-1=1023 returns correct data.
